// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter slice.
//   pptr_t       physical line address
//   cacheline_t  one cache line of data
//   arb_state_t  arbiter FSM state encoding (IDLE is all-zero)
//   requester_t  identifies which cache owns a transaction
package mem_port_arbiter_pkg;

    typedef logic [31:0]  pptr_t;
    typedef logic [127:0] cacheline_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational.
//   req[0]  I-cache is requesting
//   req[1]  D-cache is requesting
//   last    requester served most recently
//   grant   one-hot winner (bit0 = IC, bit1 = DC), 0 when nobody requests
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  requester_t last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that was not served last wins.
            2'b11:   grant = (last == REQ_IC) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between I-cache refills and D-cache
// refills/writebacks, one outstanding transaction at a time.
//   clk, rst                      clock, synchronous active-high reset
//   ic_req_*                      I-cache read request (level, held until ic_rec_en)
//   dc_req_*                      D-cache read/writeback request (level, held until dc_rec_en)
//   ic_rec_en / dc_rec_en         1-cycle response pulse to the owning cache
//   rec_addr / rec_cacheline      address and read data of the returned transaction
//   mem_req_*                     memory command; mem_req_valid is a 1-cycle strobe
//   mem_rsp_valid / mem_rsp_data  memory completion pulse and read data
//   err_timeout                   sticky abort flag, cleared only by rst
//   dbg_state                     current FSM state for observation
// Handshake: requests are levels sampled only in IDLE; once latched the
// command is frozen until the response pulse, and mem_rsp_valid is only
// honoured while waiting for memory.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ic_req_ren,
    input  pptr_t      ic_req_addr,
    input  logic       dc_req_ren,
    input  logic       dc_req_wen,
    input  pptr_t      dc_req_addr,
    input  cacheline_t dc_req_data,
    output logic       ic_rec_en,
    output logic       dc_rec_en,
    output pptr_t      rec_addr,
    output cacheline_t rec_cacheline,
    output logic       mem_req_valid,
    output logic       mem_req_we,
    output pptr_t      mem_req_addr,
    output cacheline_t mem_req_data,
    input  logic       mem_rsp_valid,
    input  cacheline_t mem_rsp_data,
    output logic       err_timeout,
    output arb_state_t dbg_state
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_t       state_q, state_d;
    requester_t       owner_q, owner_d;
    requester_t       last_grant_q, last_grant_d;
    logic             mask_q, mask_d;
    pptr_t            addr_q, addr_d;
    logic             we_q, we_d;
    cacheline_t       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    logic             ic_rec_en_q, ic_rec_en_d;
    logic             dc_rec_en_q, dc_rec_en_d;
    cacheline_t       rec_line_q, rec_line_d;

    logic [1:0]       req_vec;
    logic [1:0]       grant;
    logic [CNT_W-1:0] cnt_inc;

    // The requester served last is masked for one IDLE cycle so a cache
    // that drops its level a cycle late does not get a duplicate access.
    always_comb begin
        req_vec = {dc_req_ren | dc_req_wen, ic_req_ren};
        if (mask_q && (last_grant_q == REQ_IC)) req_vec[0] = 1'b0;
        if (mask_q && (last_grant_q == REQ_DC)) req_vec[1] = 1'b0;
    end

    rr_pick2 u_pick (
        .req   (req_vec),
        .last  (last_grant_q),
        .grant (grant)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        mask_d          = (state_q == ARB_RESP);
        addr_d          = addr_q;
        we_d            = we_q;
        data_d          = data_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        mem_req_valid_d = 1'b0;
        ic_rec_en_d     = 1'b0;
        dc_rec_en_d     = 1'b0;
        rec_line_d      = rec_line_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant[1]) begin
                    // Writeback takes priority over a simultaneous D-cache read.
                    owner_d         = REQ_DC;
                    addr_d          = dc_req_addr;
                    we_d            = dc_req_wen;
                    data_d          = dc_req_wen ? dc_req_data : '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ARB_ISSUE;
                end else if (grant[0]) begin
                    owner_d         = REQ_IC;
                    addr_d          = ic_req_addr;
                    we_d            = 1'b0;
                    data_d          = '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_rsp_valid) begin
                    rec_line_d  = we_q ? '0 : mem_rsp_data;
                    ic_rec_en_d = (owner_q == REQ_IC);
                    dc_rec_en_d = (owner_q == REQ_DC);
                    state_d     = ARB_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT)) begin
                        err_d       = 1'b1;
                        rec_line_d  = '0;
                        ic_rec_en_d = (owner_q == REQ_IC);
                        dc_rec_en_d = (owner_q == REQ_DC);
                        state_d     = ARB_RESP;
                    end
                end
            end
            ARB_RESP: begin
                last_grant_d = owner_q;
                state_d      = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ARB_IDLE;
            owner_q         <= REQ_IC;
            last_grant_q    <= REQ_DC;
            mask_q          <= 1'b0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            data_q          <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            ic_rec_en_q     <= 1'b0;
            dc_rec_en_q     <= 1'b0;
            rec_line_q      <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            mask_q          <= mask_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            data_q          <= data_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            mem_req_valid_q <= mem_req_valid_d;
            ic_rec_en_q     <= ic_rec_en_d;
            dc_rec_en_q     <= dc_rec_en_d;
            rec_line_q      <= rec_line_d;
        end
    end

    // The latched command is frozen from IDLE until RESP, so it serves
    // directly as both the memory command and the returned address.
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = data_q;
    assign ic_rec_en     = ic_rec_en_q;
    assign dc_rec_en     = dc_rec_en_q;
    assign rec_addr      = addr_q;
    assign rec_cacheline = rec_line_q;
    assign err_timeout   = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int RSP_W = 2 + 32 + 128;
    localparam int CMD_W = 1 + 32 + 128;

    localparam cacheline_t D_A5   = {16{8'hA5}};
    localparam cacheline_t D_DEAD = {8{16'hDEAD}};
    localparam cacheline_t D_BEEF = {8{16'hBEEF}};
    localparam cacheline_t D_ONES = {128{1'b1}};
    localparam cacheline_t D_1    = {4{32'h1111_0001}};
    localparam cacheline_t D_2    = {4{32'h2222_0002}};
    localparam cacheline_t D_3    = {4{32'h3333_0003}};
    localparam cacheline_t D_4    = {4{32'h4444_0004}};
    localparam cacheline_t D_5    = {4{32'h5555_0005}};
    localparam cacheline_t D_6    = {4{32'h6666_0006}};
    localparam cacheline_t D_7    = {4{32'h7777_0007}};

    // clock / reset / DUT signals
    logic       clk = 1'b0;
    logic       rst;
    logic       ic_req_ren;
    pptr_t      ic_req_addr;
    logic       dc_req_ren;
    logic       dc_req_wen;
    pptr_t      dc_req_addr;
    cacheline_t dc_req_data;
    logic       ic_rec_en;
    logic       dc_rec_en;
    pptr_t      rec_addr;
    cacheline_t rec_cacheline;
    logic       mem_req_valid;
    logic       mem_req_we;
    pptr_t      mem_req_addr;
    cacheline_t mem_req_data;
    logic       mem_rsp_valid;
    cacheline_t mem_rsp_data;
    logic       err_timeout;
    arb_state_t dbg_state;

    int total = 0;
    int bad   = 0;

    logic [RSP_W-1:0] exp_q[$];
    logic [CMD_W-1:0] exp_cmd_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req_ren    (ic_req_ren),
        .ic_req_addr   (ic_req_addr),
        .dc_req_ren    (dc_req_ren),
        .dc_req_wen    (dc_req_wen),
        .dc_req_addr   (dc_req_addr),
        .dc_req_data   (dc_req_data),
        .ic_rec_en     (ic_rec_en),
        .dc_rec_en     (dc_rec_en),
        .rec_addr      (rec_addr),
        .rec_cacheline (rec_cacheline),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .err_timeout   (err_timeout),
        .dbg_state     (dbg_state)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input logic we, input pptr_t addr, input cacheline_t data);
        exp_cmd_q.push_back({we, addr, data});
    endtask

    task automatic push_rsp(input logic ic, input pptr_t addr, input cacheline_t data);
        exp_q.push_back({ic, ~ic, addr, data});
    endtask

    // scoreboard monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (!rst) begin
            if (ic_rec_en && dc_rec_en) check("rec_en_exclusive", 2'b11, 2'b01);
            if (ic_rec_en || dc_rec_en) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {ic_rec_en, dc_rec_en, rec_addr}, 0);
                end else begin
                    check("rsp", {ic_rec_en, dc_rec_en, rec_addr, rec_cacheline}, exp_q.pop_front());
                end
            end
            if (mem_req_valid) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", {mem_req_we, mem_req_addr}, 0);
                end else begin
                    check("cmd", {mem_req_we, mem_req_addr, mem_req_data & {128{mem_req_we}}},
                          exp_cmd_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic reset_dut(input string tag);
        rst           = 1'b1;
        ic_req_ren    = 1'b0;
        dc_req_ren    = 1'b0;
        dc_req_wen    = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        tick(2);
        check({tag, "_ctrl"}, {ic_rec_en, dc_rec_en, mem_req_valid, mem_req_we, err_timeout, dbg_state}, 0);
        check({tag, "_addr"}, {rec_addr, mem_req_addr}, 0);
        check({tag, "_data"}, {rec_cacheline, mem_req_data}, 0);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_cmd(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) check({tag, "_cmd_wait"}, 0, 1);
    endtask

    // Called at the sample where the strobe is seen; the memory answers
    // `delay` cycles later and the owner's rec_en must follow one cycle after.
    task automatic respond(input string tag, input int delay, input cacheline_t d, input logic ic);
        tick(delay);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        tick(1);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        check({tag, "_rec_latency"}, {ic_rec_en, dc_rec_en}, {ic, ~ic});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ic_req_addr = '0;
        dc_req_addr = '0;
        dc_req_data = '0;
        reset_dut("reset0");

        // single IC read
        ic_req_addr = 32'h0040;
        ic_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0040, '0);
        push_rsp(1'b1, 32'h0040, D_A5);
        tick(1);
        check("t1_strobe_latency", mem_req_valid, 1);
        tick(1);
        check("t1_strobe_one_cycle", mem_req_valid, 0);
        respond("t1", 2, D_A5, 1'b1);
        ic_req_ren = 1'b0;
        tick(3);

        // tie out of reset: IC then DC
        reset_dut("reset1");
        ic_req_addr = 32'h0080;
        dc_req_addr = 32'h0200;
        ic_req_ren  = 1'b1;
        dc_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0080, '0);
        push_cmd(1'b0, 32'h0200, '0);
        push_rsp(1'b1, 32'h0080, D_1);
        push_rsp(1'b0, 32'h0200, D_2);
        wait_cmd("t2a");
        respond("t2a", 2, D_1, 1'b1);
        ic_req_ren = 1'b0;
        wait_cmd("t2b");
        respond("t2b", 1, D_2, 1'b0);
        dc_req_ren = 1'b0;
        tick(3);

        // lone IC read leaves last_grant = IC
        ic_req_addr = 32'h00C0;
        ic_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h00C0, '0);
        push_rsp(1'b1, 32'h00C0, D_3);
        wait_cmd("t2c");
        respond("t2c", 1, D_3, 1'b1);
        ic_req_ren = 1'b0;
        tick(3);

        // tie again: now DC first, then IC
        ic_req_addr = 32'h0140;
        dc_req_addr = 32'h0240;
        ic_req_ren  = 1'b1;
        dc_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0240, '0);
        push_cmd(1'b0, 32'h0140, '0);
        push_rsp(1'b0, 32'h0240, D_4);
        push_rsp(1'b1, 32'h0140, D_5);
        wait_cmd("t2d");
        respond("t2d", 1, D_4, 1'b0);
        dc_req_ren = 1'b0;
        wait_cmd("t2e");
        respond("t2e", 3, D_5, 1'b1);
        ic_req_ren = 1'b0;
        tick(3);

        // DC writeback: response data is forced to 0
        dc_req_addr = 32'h0100;
        dc_req_data = D_DEAD;
        dc_req_wen  = 1'b1;
        push_cmd(1'b1, 32'h0100, D_DEAD);
        push_rsp(1'b0, 32'h0100, '0);
        wait_cmd("t3a");
        respond("t3a", 2, D_ONES, 1'b0);
        dc_req_wen = 1'b0;
        tick(3);

        // read and write together: write first, read in a later transaction
        dc_req_addr = 32'h0180;
        dc_req_data = D_BEEF;
        dc_req_ren  = 1'b1;
        dc_req_wen  = 1'b1;
        push_cmd(1'b1, 32'h0180, D_BEEF);
        push_rsp(1'b0, 32'h0180, '0);
        push_cmd(1'b0, 32'h0180, '0);
        push_rsp(1'b0, 32'h0180, D_6);
        wait_cmd("t3b");
        respond("t3b", 1, D_ONES, 1'b0);
        dc_req_wen = 1'b0;
        wait_cmd("t3c");
        respond("t3c", 1, D_6, 1'b0);
        dc_req_ren = 1'b0;
        tick(3);

        // timeout: memory never answers
        check("t4_err_before", err_timeout, 0);
        ic_req_addr = 32'h0300;
        ic_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0300, '0);
        push_rsp(1'b1, 32'h0300, '0);
        wait_cmd("t4");
        n = 0;
        while (!(ic_rec_en || dc_rec_en) && n < 30) begin
            tick(1);
            n++;
        end
        ic_req_ren = 1'b0;
        check("t4_abort_latency", n, 9);
        check("t4_err_set", err_timeout, 1);
        tick(5);
        check("t4_err_sticky", err_timeout, 1);

        // spurious response in IDLE: ignored
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = D_7;
        tick(1);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        tick(2);
        check("t5_spurious_idle", {ic_rec_en, dc_rec_en, dbg_state, err_timeout}, {2'b00, ARB_IDLE, 1'b1});

        // reset while waiting on memory drops the transaction
        dc_req_addr = 32'h0400;
        dc_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0400, '0);
        wait_cmd("t5");
        tick(2);
        check("t5_in_wait", dbg_state, ARB_WAIT);
        reset_dut("reset_wait");
        ic_req_addr = 32'h0440;
        ic_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0440, '0);
        push_rsp(1'b1, 32'h0440, D_2);
        tick(1);
        check("t5_post_reset_strobe", mem_req_valid, 1);
        respond("t5", 1, D_2, 1'b1);
        ic_req_ren = 1'b0;
        tick(3);

        // IC holds its level one cycle past ic_rec_en: no second access
        ic_req_addr = 32'h0500;
        ic_req_ren  = 1'b1;
        push_cmd(1'b0, 32'h0500, '0);
        push_rsp(1'b1, 32'h0500, D_7);
        wait_cmd("t6");
        respond("t6", 1, D_7, 1'b1);
        tick(1);
        ic_req_ren = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (mem_req_valid) n++;
        end
        check("t6_no_reissue", n, 0);

        tick(2);
        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("rsp_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
